id_restore_table: RTL
=====================

ID_RESTORE_TABLE -- requirements
Module: id_restore_table

Interface
REQ-001 Parameter InIdWidth, default 8: ID width of the wide (slave-side) ID restored on responses.
REQ-002 Parameter OutIdWidth, default 2: ID width of the narrow (master-side) ID; table has NumEntries = 2**OutIdWidth entries.
REQ-003 Parameter MaxTxnsPerId, default 4: max in-flight transactions per entry; counter width CntW = $clog2(MaxTxnsPerId+1).
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 push_valid_i  input  1  request-side handshake valid (AW/AR accepted).
REQ-007 push_ready_o  output  1  table can accept push this cycle.
REQ-008 push_id_i  input  InIdWidth  wide ID of new request.
REQ-009 push_oup_id_o  output  OutIdWidth  narrow ID assigned to push_id_i; valid while push_ready_o=1.
REQ-010 pop_valid_i  input  1  response beat handshake (B, or R beat).
REQ-011 pop_last_i  input  1  beat completes a transaction (B always 1; R last).
REQ-012 pop_oup_id_i  input  OutIdWidth  narrow ID carried by response.
REQ-013 pop_inp_id_o  output  InIdWidth  restored wide ID for pop_oup_id_i, combinational.
REQ-014 full_o  output  1  no free entry.
REQ-015 empty_o  output  1  all entries free.
REQ-016 err_o  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-017 Each entry SHALL hold id[InIdWidth] and cnt[CntW]; entry is live iff cnt != 0.
REQ-018 Push lookup SHALL use registered state only: if a live entry has id == push_id_i, it is the match entry.
REQ-019 Match with cnt < MaxTxnsPerId: push_ready_o=1, push_oup_id_o = match index.
REQ-020 Match with cnt == MaxTxnsPerId: push_ready_o=0 (preserves per-ID ordering; no second entry for same ID).
REQ-021 No match: push_ready_o=1 and push_oup_id_o = lowest-index free entry if any, else push_ready_o=0.
REQ-022 push_oup_id_o SHALL be 0 when push_ready_o=0.
REQ-023 Push fires when push_valid_i && push_ready_o: selected entry cnt += 1; id written on new allocation.
REQ-024 pop_inp_id_o SHALL equal id of entry pop_oup_id_i, zero-latency, regardless of liveness.
REQ-025 Pop fires when pop_valid_i && pop_last_i on live entry: cnt -= 1; non-last beats change no state.
REQ-026 Same-entry push and pop in one cycle: cnt unchanged; entry at cnt 1 stays live with same id.
REQ-027 Entry freed by a pop SHALL NOT be reallocated until next cycle (no same-cycle bypass).
REQ-028 Pop (last) to a free entry SHALL leave cnt at 0 (no underflow).
REQ-029 full_o = all cnt != 0; empty_o = all cnt == 0; both from registered state.
REQ-030 Push and pop to different entries in one cycle SHALL both take effect.

Reset
REQ-031 rst_i asserted SHALL immediately clear all cnt, id and err_o to 0, independent of clk_i.
REQ-032 During/after reset: push_ready_o=1, push_oup_id_o=0, empty_o=1, full_o=0, err_o=0, pop_inp_id_o=0.
REQ-033 Reset mid-operation SHALL discard all in-flight mappings; no pop after reset restores pre-reset IDs.

Configuration
REQ-034 Macro ID_RESTORE_ERR_CHECK_EN: when defined, err_o SHALL set (next edge) on pop_valid_i && pop_last_i to a free entry, and stay set until reset.
REQ-035 Without ID_RESTORE_ERR_CHECK_EN, err_o SHALL be tied 0 and no error logic synthesised; REQ-028 still holds.

Verification
REQ-036 Reset, push id 0x5A -> push_oup_id_o=0; next cycle push 0x5A -> oup 0; pop oup 0 last twice -> empty_o=1.
REQ-037 Push 0x11,0x22,0x33,0x44 (defaults) -> oup 0,1,2,3, full_o=1; push 0x55 -> push_ready_o=0; push 0x22 -> ready 1, oup 1.
REQ-038 Push 0x7 four times -> entry 0 cnt 4; fifth push 0x7 -> push_ready_o=0 until one pop last on oup 0.
REQ-039 Entry 2 cnt 1 (id 0x9C): same cycle push 0x9C and pop last oup 2 -> cnt stays 1, pop_inp_id_o=0x9C, empty_o=0.
REQ-040 Pop last to free entry 3 -> with ID_RESTORE_ERR_CHECK_EN err_o=1 next cycle, held until rst_i; without, err_o=0; cnt stays 0.
REQ-041 Three entries live, assert rst_i asynchronously mid-cycle -> all outputs at REQ-032 values before next clk_i edge.

Source files
------------

// File: rtl/id_restore_table.sv
// ID restore table: maps wide request IDs onto narrow table indices and
// restores them on responses. Optional macro: ID_RESTORE_ERR_CHECK_EN.
module id_restore_table #(
  parameter int InIdWidth    = 8,
  parameter int OutIdWidth   = 2,
  parameter int MaxTxnsPerId = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [InIdWidth-1:0]  push_id_i,
  output logic [OutIdWidth-1:0] push_oup_id_o,
  input  logic                  pop_valid_i,
  input  logic                  pop_last_i,
  input  logic [OutIdWidth-1:0] pop_oup_id_i,
  output logic [InIdWidth-1:0]  pop_inp_id_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  err_o
);

  localparam int NumEntries = 2**OutIdWidth;
  localparam int CntW       = $clog2(MaxTxnsPerId+1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxnsPerId);

  logic [InIdWidth-1:0]  r_id  [NumEntries];
  logic [CntW-1:0]       r_cnt [NumEntries];

  logic                  w_hit;
  logic                  w_free;
  logic [OutIdWidth-1:0] w_hit_idx;
  logic [OutIdWidth-1:0] w_free_idx;
  logic [OutIdWidth-1:0] w_sel;
  logic                  w_ready;
  logic                  w_all_live;
  logic                  w_all_free;
  logic                  w_push_fire;
  logic                  w_pop_fire;

  // Scan registered entries: live-ID match and lowest-index free slot
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_all_live = 1'b1;
    w_all_free = 1'b1;
    for (int i = NumEntries-1; i >= 0; i--) begin
      if (r_cnt[i] == '0) begin
        w_free     = 1'b1;
        w_free_idx = OutIdWidth'(i);
        w_all_live = 1'b0;
      end else begin
        w_all_free = 1'b0;
        if (r_id[i] == push_id_i) begin
          w_hit     = 1'b1;
          w_hit_idx = OutIdWidth'(i);
        end
      end
    end
  end

  // A matching ID must reuse its entry so per-ID ordering is preserved
  always_comb begin
    w_sel   = w_hit ? w_hit_idx : w_free_idx;
    w_ready = w_hit ? (r_cnt[w_hit_idx] < CntMax) : w_free;
  end

  assign w_push_fire   = push_valid_i & w_ready;
  assign w_pop_fire    = pop_valid_i & pop_last_i &
                         (r_cnt[pop_oup_id_i] != '0);
  assign push_ready_o  = w_ready;
  assign push_oup_id_o = w_ready ? w_sel : '0;
  assign pop_inp_id_o  = r_id[pop_oup_id_i];
  assign full_o        = w_all_live;
  assign empty_o       = w_all_free;

  // Per-entry counters and IDs; push and pop on one entry cancel out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumEntries; i++) begin
        r_id[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumEntries; i++) begin
        if (w_push_fire && (w_sel == OutIdWidth'(i))) begin
          if (!(w_pop_fire && (pop_oup_id_i == OutIdWidth'(i)))) begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
          if (!w_hit) begin
            r_id[i] <= push_id_i;
          end
        end else if (w_pop_fire && (pop_oup_id_i == OutIdWidth'(i))) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

`ifdef ID_RESTORE_ERR_CHECK_EN
  logic r_err;

  // Sticky flag: a completing response named an entry with nothing in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (pop_valid_i && pop_last_i &&
                 (r_cnt[pop_oup_id_i] == '0)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule
